i2c_master_read_bits: RTL and testbench

Parametrised I2C master receive engine: clocks in `DATA_BITS` bits MSB-first from a slave, then drives an ACK or NACK bit. It enforces a clock-stretch timeout on every rising SCL edge and generates SCL timing from a quarter-period divider. It sits below the transaction controller, which handles START/STOP and address phases and ORs this block's open-drain enables with those of the other bit-level engines.

---
 rtl/i2c_master_pkg.sv | 6 +
 rtl/i2c_line_sync.sv | 12 +
 rtl/i2c_master_read_bits.sv | 118 +++++++++++
 tb/tb_i2c_master_read_bits.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: bit-engine state encoding and open-drain line levels shared by the I2C engines
package i2c_master_pkg;
    typedef enum logic [2:0] {IDLE, LOW, RISE, HIGH, FALL, DONE} state_t;
    localparam logic RELEASE  = 1'b0;
    localparam logic PULL_LOW = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizer for an idle-high bus line
module i2c_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clock)
        if (reset) {q, meta} <= 2'b11;
        else       {q, meta} <= {meta, d};
endmodule

// File: rtl/i2c_master_read_bits.sv
// i2c_master_read_bits: I2C master receive engine, MSB-first read then ACK/NACK, with SCL stretch timeout; I2C_READ_INPUT_SYNC_EN adds input synchronizers
module i2c_master_read_bits
    import i2c_master_pkg::*;
#(
    parameter int DATA_BITS              = 8,
    parameter int QUARTER_CYCLES         = 125,
    parameter int STRETCH_TIMEOUT_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 send_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [DATA_BITS-1:0] data,
    input  logic                 sda_in,
    input  logic                 scl_in,
    output logic                 sda_oe,
    output logic                 scl_oe
);
    localparam int QW = $clog2(2 * QUARTER_CYCLES + 1);
    localparam int SW = $clog2(STRETCH_TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS + 2);
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER_CYCLES - 1);
    localparam logic [QW-1:0] H_LAST = QW'(2 * QUARTER_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STRETCH_TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] B_ACK  = BW'(DATA_BITS);
    localparam logic [BW-1:0] B_PRE  = BW'(DATA_BITS - 1);

    state_t        state;
    logic [QW-1:0] cnt;
    logic [SW-1:0] stretch;
    logic [BW-1:0] bit_cnt;
    logic          ack;
    logic          sda_s, scl_s;

`ifdef I2C_READ_INPUT_SYNC_EN
    i2c_line_sync u_sda_sync (.clock(clock), .reset(reset), .d(sda_in), .q(sda_s));
    i2c_line_sync u_scl_sync (.clock(clock), .reset(reset), .d(scl_in), .q(scl_s));
`else
    assign sda_s = sda_in;
    assign scl_s = scl_in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            data    <= '0;
            sda_oe  <= RELEASE;
            scl_oe  <= RELEASE;
            cnt     <= '0;
            stretch <= '0;
            bit_cnt <= '0;
            ack     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= LOW;
                    busy    <= 1'b1;
                    ack     <= send_ack;
                    data    <= '0;
                    bit_cnt <= '0;
                    cnt     <= '0;
                    scl_oe  <= PULL_LOW;
                    sda_oe  <= RELEASE;
                end
                LOW: if (cnt == Q_LAST) begin
                    cnt     <= '0;
                    stretch <= '0;
                    scl_oe  <= RELEASE;
                    state   <= RISE;
                end else cnt <= cnt + 1'b1;
                RISE: if (scl_s) state <= HIGH;
                else if (stretch == S_LAST) begin
                    // A stretch timeout abandons the byte: no ACK, both lines released
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                    sda_oe  <= RELEASE;
                end else stretch <= stretch + 1'b1;
                HIGH: begin
                    if (cnt == Q_LAST && bit_cnt != B_ACK) data <= (data << 1) | DATA_BITS'(sda_s);
                    if (cnt == H_LAST) begin
                        cnt    <= '0;
                        scl_oe <= PULL_LOW;
                        state  <= FALL;
                    end else cnt <= cnt + 1'b1;
                end
                FALL: if (cnt == Q_LAST) begin
                    cnt     <= '0;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == B_ACK) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        sda_oe <= RELEASE;
                    end else begin
                        state  <= LOW;
                        sda_oe <= (bit_cnt == B_PRE && ack) ? PULL_LOW : RELEASE;
                    end
                end else cnt <= cnt + 1'b1;
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    timeout <= 1'b0;
                    scl_oe  <= RELEASE;
                    sda_oe  <= RELEASE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_read_bits.sv
// tb_i2c_master_read_bits: vector table plus randomized reads against a timing/data model with a behavioural slave
module tb_i2c_master_read_bits;
    localparam int N = 8, Q = 2, T = 50, BIT = 4 * Q + 1;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, send_ack = 1'b0;
    logic busy, done, timeout, sda_oe, scl_oe, sda_in, scl_in;
    logic [N-1:0] data;
    logic slave_low = 1'b0, hold_low = 1'b0;

    assign sda_in = !(sda_oe || slave_low);
    assign scl_in = !(scl_oe || hold_low);

    always #5 clock = ~clock;

    i2c_master_read_bits #(.DATA_BITS(N), .QUARTER_CYCLES(Q), .STRETCH_TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .start(start), .send_ack(send_ack),
        .busy(busy), .done(done), .timeout(timeout), .data(data),
        .sda_in(sda_in), .scl_in(scl_in), .sda_oe(sda_oe), .scl_oe(scl_oe)
    );

    int passed = 0, total = 0;
    int idx, rel, hold_cnt, sb, sl;
    bit prev_scl_oe, prev_line;
    logic [N-1:0] sbyte;

    typedef struct {
        logic [7:0] b; bit a; int sb; int sl; int abort; bit poke;
        int ed; int ecyc; int eto; int esda; int efirst;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Slave: presents bit idx while SCL is low, holds SCL low for sl cycles on release number sb
    task automatic slave_step();
        bit line;
        if (prev_scl_oe && !scl_oe) begin
            if (rel == sb) hold_cnt = sl;
            rel++;
        end else if (hold_cnt > 0) hold_cnt--;
        prev_scl_oe = scl_oe;
        hold_low = hold_cnt > 0;
        line = !(scl_oe || hold_low);
        if (prev_line && !line) idx++;
        prev_line = line;
        slave_low = (idx >= 0 && idx < N) ? !sbyte[N-1-idx] : 1'b0;
    endtask

    function automatic void model(input logic [7:0] b, input bit a, input int sbi, input int sli,
                                  output int ed, output int ecyc, output int eto, output int esda, output int efirst);
        int extra;
        extra = (sbi >= 0) ? sli : 0;
        if (sbi >= 0 && sli >= T) begin
            ed = int'(b) >> (N - sbi); ecyc = sbi * BIT + Q + T; eto = 1; esda = 0; efirst = -1;
        end else begin
            ed = int'(b); ecyc = (N + 1) * BIT + extra; eto = 0;
            esda = a ? BIT : 0; efirst = a ? N * BIT + extra : -1;
        end
    endfunction

    task automatic run(input vec_t v, input string tag);
        int cyc = 0, scnt = 0, first = -1, busy_err = 0, dones = 0;
        bit seen = 0;
        @(negedge clock);
        sbyte = v.b; sb = v.sb; sl = v.sl; idx = -1; rel = 0; hold_cnt = 0;
        prev_scl_oe = scl_oe; prev_line = 1'b1; slave_low = 1'b0; hold_low = 1'b0;
        send_ack = v.a; start = 1'b1;
        @(negedge clock);
        start = 1'b0; send_ack = !v.a;
        chk({tag, " busy_after_start"}, int'(busy), 1);
        while (cyc < 3000) begin
            slave_step();
            if (sda_oe) begin scnt++; if (first < 0) first = cyc; end
            if (v.abort >= 0 && idx == v.abort) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk({tag, " rst_busy"}, int'(busy), 0);
                chk({tag, " rst_oe"}, int'({scl_oe, sda_oe}), 0);
                chk({tag, " rst_data"}, int'(data), 0);
                slave_low = 1'b0; hold_low = 1'b0; hold_cnt = 0;
                for (int i = 0; i < 5; i++) begin
                    if (done) dones++;
                    @(negedge clock);
                end
                chk({tag, " rst_no_done"}, dones, 0);
                return;
            end
            if (done) begin seen = 1; break; end
            if (!busy) busy_err++;
            start = v.poke && cyc == 10;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, int'(seen), 1);
        if (!seen) begin slave_low = 1'b0; hold_low = 1'b0; hold_cnt = 0; return; end
        chk({tag, " cycles"}, cyc, v.ecyc);
        chk({tag, " timeout"}, int'(timeout), v.eto);
        chk({tag, " data"}, int'(data), v.ed);
        chk({tag, " scl_oe_done"}, int'(scl_oe), v.eto ? 0 : 1);
        chk({tag, " sda_oe_done"}, int'(sda_oe), 0);
        chk({tag, " busy_done"}, int'(busy), 0);
        chk({tag, " busy_gaps"}, busy_err, 0);
        chk({tag, " sda_cycles"}, scnt, v.esda);
        chk({tag, " sda_first"}, first, v.efirst);
        slave_low = 1'b0; hold_low = 1'b0; hold_cnt = 0;
        if (v.poke) start = 1'b1;
        @(negedge clock);
        chk({tag, " after_done"}, int'({done, timeout, scl_oe, sda_oe, busy}), 0);
        if (v.poke) begin
            @(negedge clock);
            start = 1'b0;
            chk({tag, " restart_busy"}, int'(busy), 1);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{8'hA5, 1, -1, 0, -1, 0, 8'hA5, 81, 0, 9, 72};
        tbl[1] = '{8'hA5, 0, -1, 0, -1, 0, 8'hA5, 81, 0, 0, -1};
        tbl[2] = '{8'h3C, 1, 2, 20, -1, 0, 8'h3C, 101, 0, 9, 92};
        tbl[3] = '{8'hA5, 1, 1, 1000, -1, 0, 8'h01, 61, 1, 0, -1};
        tbl[4] = '{8'h5A, 1, -1, 0, 4, 0, 8'h00, 0, 0, 0, -1};
        tbl[5] = '{8'h5A, 0, -1, 0, -1, 1, 8'h5A, 81, 0, 0, -1};
        repeat (3) @(negedge clock);
        chk("reset_outputs", int'({busy, done, timeout, sda_oe, scl_oe}), 0);
        chk("reset_data", int'(data), 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) run(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 24; i++) begin
            int mode;
            rv.b = 8'($urandom);
            rv.a = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            rv.sb = (mode == 0) ? -1 : int'($urandom_range(0, N - 1));
            rv.sl = (mode == 3) ? int'($urandom_range(T, T + 40)) : (mode == 0 ? 0 : int'($urandom_range(0, 30)));
            rv.abort = -1;
            rv.poke = 0;
            model(rv.b, rv.a, rv.sb, rv.sl, rv.ed, rv.ecyc, rv.eto, rv.esda, rv.efirst);
            run(rv, $sformatf("rnd%0d", i));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
